// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
// Port selection tags and index-width helper.
package dpram_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 6;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        SEL_A,
        SEL_B,
        SEL_NONE
    } port_sel_t;

endpackage

// File: rtl/dpram_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of req&mask
// at or after start, wrapping past N-1 to 0.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = IDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0] cand;

    assign cand = req & mask;

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && cand[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Arbitrates NUM_REQ requesters onto the two ports of a
// synchronous dual-port RAM and routes read data back.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]         ram_addr_a,
    output logic [ADDR_W-1:0]         ram_addr_b,
    output logic [DATA_W-1:0]         ram_data_a,
    output logic [DATA_W-1:0]         ram_data_b,
    output logic                      ram_we_a,
    output logic                      ram_we_b,
    input  logic [DATA_W-1:0]         ram_q_a,
    input  logic [DATA_W-1:0]         ram_q_b
);

    localparam int IW = idx_w(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]        vld;
    logic [NUM_REQ-1:0]        mask_b;
    logic [IW-1:0]             rr_ptr;
    logic [IW-1:0]             ga;
    logic [IW-1:0]             gb;
    logic                      ga_ok;
    logic                      gb_ok;
    logic [ADDR_W-1:0]         addr_ga;
    logic                      we_ga;
    logic [NUM_REQ*DATA_W-1:0] rdata_q;
    port_sel_t                 tag [NUM_REQ];

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    // Gating with rst_n keeps every grant-driven output idle in reset.
    assign vld     = req_valid & {NUM_REQ{rst_n}};
    assign addr_ga = req_addr[int'(ga)*ADDR_W +: ADDR_W];
    assign we_ga   = req_we[ga];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick_a (
        .req   (vld),
        .mask  ({NUM_REQ{1'b1}}),
        .start (rr_ptr),
        .found (ga_ok),
        .idx   (ga)
    );

    // Port B skips gA and anyone hitting gA's address unless both read.
    always_comb begin
        mask_b = '1;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ga_ok && (IW'(j) == ga)) begin
                mask_b[j] = 1'b0;
            end else if (ga_ok
                         && (req_addr[j*ADDR_W +: ADDR_W] == addr_ga)
                         && (we_ga || req_we[j])) begin
                mask_b[j] = 1'b0;
            end
        end
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick_b (
        .req   (vld),
        .mask  (mask_b),
        .start (rr_ptr),
        .found (gb_ok),
        .idx   (gb)
    );

    always_comb begin
        req_ready  = '0;
        ram_addr_a = '0;
        ram_data_a = '0;
        ram_we_a   = 1'b0;
        ram_addr_b = '0;
        ram_data_b = '0;
        ram_we_b   = 1'b0;
        if (ga_ok) begin
            req_ready[ga] = 1'b1;
            ram_addr_a    = addr_ga;
            ram_data_a    = req_wdata[int'(ga)*DATA_W +: DATA_W];
            ram_we_a      = we_ga;
        end
        if (gb_ok) begin
            req_ready[gb] = 1'b1;
            ram_addr_b    = req_addr[int'(gb)*ADDR_W +: ADDR_W];
            ram_data_b    = req_wdata[int'(gb)*DATA_W +: DATA_W];
            ram_we_b      = req_we[gb];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tag[i] <= SEL_NONE;
            end
        end else begin
            if (gb_ok) begin
                rr_ptr <= nxt(gb);
            end else if (ga_ok) begin
                rr_ptr <= nxt(ga);
            end
            rdata_q <= rsp_rdata;
            for (int i = 0; i < NUM_REQ; i++) begin
                tag[i] <= SEL_NONE;
                if (ga_ok && (ga == IW'(i)) && !req_we[i]) begin
                    tag[i] <= SEL_A;
                end
                if (gb_ok && (gb == IW'(i)) && !req_we[i]) begin
                    tag[i] <= SEL_B;
                end
            end
        end
    end

    // RAM data arrives the cycle after the grant, so the pulse cycle
    // passes ram_q straight through and the register holds it after.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = rdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            case (tag[i])
                SEL_A: begin
                    rsp_valid[i]                  = 1'b1;
                    rsp_rdata[i*DATA_W +: DATA_W] = ram_q_a;
                end
                SEL_B: begin
                    rsp_valid[i]                  = 1'b1;
                    rsp_rdata[i*DATA_W +: DATA_W] = ram_q_b;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter with a behavioural dual-port RAM
// and a read-response scoreboard.
module tb_dpram_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_rdata;
    logic [AW-1:0]   ram_addr_a;
    logic [AW-1:0]   ram_addr_b;
    logic [DW-1:0]   ram_data_a;
    logic [DW-1:0]   ram_data_b;
    logic            ram_we_a;
    logic            ram_we_b;
    logic [DW-1:0]   ram_q_a;
    logic [DW-1:0]   ram_q_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] shadow [64];
    logic [7:0] mem [64];

    dpram_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_a (ram_data_a),
        .ram_data_b (ram_data_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_q_a    (ram_q_a),
        .ram_q_b    (ram_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Pop last cycle's expected reads, then record this cycle's grants.
    always @(negedge clk) begin : mon
        int   n;
        exp_t e;
        n = 0;
        if (!rst_n) begin
            sb.delete();
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("sb_valid", 32'(rsp_valid[e.idx]), 32'h1);
                chk("sb_rdata", 32'(rsp_rdata[e.idx*DW +: DW]),
                    32'(e.data));
                n++;
            end
            chk("sb_count", 32'($countones(rsp_valid)), 32'(n));
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i] && !req_we[i]) begin
                    e.idx  = i;
                    e.data = shadow[req_addr[i*AW +: AW]];
                    e.cyc  = cyc;
                    sb.push_back(e);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i] && req_we[i]) begin
                    shadow[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
                end
            end
        end
    end

    task automatic drive(input int i, input logic we,
                         input logic [5:0] a, input logic [7:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        tick();
        idle();
        rst_n = 1'b0;
        samp();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        #1 rst_n = 1'b0;

        // reset state with a request already waiting
        drive(0, 1'b1, 6'h01, 8'h33);
        samp();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we_a", 32'(ram_we_a), 32'h0);
        chk("rst_addr_a", 32'(ram_addr_a), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_ptr", 32'(dut.rr_ptr), 32'h0);
        tick();
        rst_n = 1'b1;

        // single write then read
        samp();
        chk("wr_ready", 32'(req_ready), 32'h1);
        chk("wr_we_a", 32'(ram_we_a), 32'h1);
        chk("wr_addr_a", 32'(ram_addr_a), 32'h01);
        chk("wr_data_a", 32'(ram_data_a), 32'h33);
        chk("wr_we_b", 32'(ram_we_b), 32'h0);
        tick();
        drive(0, 1'b0, 6'h01, 8'h00);
        samp();
        chk("rd_ready", 32'(req_ready), 32'h1);
        tick();
        idle();
        samp();
        chk("rd_valid", 32'(rsp_valid), 32'h1);
        chk("rd_data", 32'(rsp_rdata[7:0]), 32'h33);
        tick();
        samp();
        chk("rd_pulse", 32'(rsp_valid), 32'h0);
        chk("rd_hold", 32'(rsp_rdata[7:0]), 32'h33);
        reset_dut();

        // dual grant
        drive(0, 1'b1, 6'h02, 8'h44);
        drive(1, 1'b1, 6'h03, 8'h55);
        samp();
        chk("dual_ready", 32'(req_ready), 32'h3);
        chk("dual_we_a", 32'(ram_we_a), 32'h1);
        chk("dual_we_b", 32'(ram_we_b), 32'h1);
        chk("dual_addr_a", 32'(ram_addr_a), 32'h02);
        chk("dual_addr_b", 32'(ram_addr_b), 32'h03);
        chk("dual_data_b", 32'(ram_data_b), 32'h55);
        tick();
        idle();
        samp();
        chk("dual_ptr", 32'(dut.rr_ptr), 32'h2);
        reset_dut();

        // same-address write conflict
        drive(1, 1'b1, 6'h05, 8'h66);
        drive(2, 1'b1, 6'h05, 8'h77);
        samp();
        chk("cf_ready", 32'(req_ready), 32'h2);
        chk("cf_we_b", 32'(ram_we_b), 32'h0);
        tick();
        req_valid[1] = 1'b0;
        samp();
        chk("cf_ready2", 32'(req_ready), 32'h4);
        chk("cf_addr_a", 32'(ram_addr_a), 32'h05);
        tick();
        idle();
        drive(0, 1'b0, 6'h05, 8'h00);
        samp();
        chk("cf_rd_ready", 32'(req_ready), 32'h1);
        tick();
        idle();
        samp();
        chk("cf_rd_data", 32'(rsp_rdata[7:0]), 32'h77);

        // shared read of one address
        drive(0, 1'b0, 6'h01, 8'h00);
        drive(3, 1'b0, 6'h01, 8'h00);
        samp();
        chk("sh_ready", 32'(req_ready), 32'h9);
        chk("sh_addr_b", 32'(ram_addr_b), 32'h01);
        tick();
        idle();
        samp();
        chk("sh_valid", 32'(rsp_valid), 32'h9);
        chk("sh_d0", 32'(rsp_rdata[7:0]), 32'h33);
        chk("sh_d3", 32'(rsp_rdata[31:24]), 32'h33);
        reset_dut();

        // fairness with all four reading continuously
        drive(0, 1'b0, 6'h01, 8'h00);
        drive(1, 1'b0, 6'h02, 8'h00);
        drive(2, 1'b0, 6'h03, 8'h00);
        drive(3, 1'b0, 6'h05, 8'h00);
        for (int k = 0; k < 3; k++) begin
            samp();
            chk("fair_ready", 32'(req_ready),
                (k == 1) ? 32'hc : 32'h3);
            chk("fair_ptr", 32'(dut.rr_ptr),
                (k == 1) ? 32'h2 : 32'h0);
            tick();
        end
        idle();
        samp();

        // pointer wrap: ptr 3, grant at 1 -> ptr 2
        reset_dut();
        drive(2, 1'b0, 6'h03, 8'h00);
        samp();
        tick();
        idle();
        drive(1, 1'b0, 6'h02, 8'h00);
        samp();
        chk("wrap_ptr3", 32'(dut.rr_ptr), 32'h3);
        chk("wrap_ready", 32'(req_ready), 32'h2);
        tick();
        idle();
        samp();
        chk("wrap_ptr2", 32'(dut.rr_ptr), 32'h2);

        // reset while a read and a write are granted
        tick();
        drive(2, 1'b0, 6'h03, 8'h00);
        drive(3, 1'b1, 6'h06, 8'h99);
        samp();
        chk("mr_ready", 32'(req_ready), 32'hc);
        chk("mr_we_b", 32'(ram_we_b), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_we_a_rst", 32'(ram_we_a), 32'h0);
        chk("mr_we_b_rst", 32'(ram_we_b), 32'h0);
        chk("mr_ready_rst", 32'(req_ready), 32'h0);
        chk("mr_ptr_rst", 32'(dut.rr_ptr), 32'h0);
        idle();
        samp();
        tick();
        rst_n = 1'b1;
        samp();
        chk("mr_rsp", 32'(rsp_valid), 32'h0);
        chk("mr_ptr", 32'(dut.rr_ptr), 32'h0);
        tick();
        samp();
        chk("mr_rsp2", 32'(rsp_valid), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
